// File: rtl/tft_pkg.sv
// Shared definitions for the TFT pixel-clock monitor: widths, lock FSM encoding
// and the tolerance distance helper.
package tft_pkg;

    localparam int TFT_DIV_W  = 16;
    localparam int TFT_HALF_W = 17;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ACQ_FIRST = 2'd1;
    localparam logic [1:0] ST_ACQUIRE   = 2'd2;
    localparam logic [1:0] ST_LOCKED    = 2'd3;

    // Ordered subtraction so the distance never wraps, widened by one bit.
    function automatic logic [TFT_HALF_W:0] tft_abs_diff(
        input logic [TFT_HALF_W-1:0] a,
        input logic [TFT_HALF_W-1:0] b
    );
        logic [TFT_HALF_W-1:0] d;
        d = (a >= b) ? (a - b) : (b - a);
        return {1'b0, d};
    endfunction

endpackage

// File: rtl/tft_pclk_monitor_if.sv
// Pixel-clock input and recovered-divide status bundle between the monitor
// and its consumers (status registers / display path).
interface tft_pclk_monitor_if;

    logic                            pclk_in;
    logic [tft_pkg::TFT_DIV_W-1:0]   clock_divide;
    logic                            lock;
    logic                            meas_stb;
    logic [tft_pkg::TFT_HALF_W-1:0]  meas_value;
    logic                            timeout;

    modport master (
        input  pclk_in,
        output clock_divide, lock, meas_stb, meas_value, timeout
    );

    modport slave (
        output pclk_in,
        input  clock_divide, lock, meas_stb, meas_value, timeout
    );

endinterface

// File: rtl/tft_pclk_sync.sv
// Synchronizes the asynchronous pixel clock into clk and flags every transition
// with a one-cycle registered pulse.
module tft_pclk_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pclk_in,
    output logic pclk_edge
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   last_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= '0;
            last_q    <= 1'b0;
            pclk_edge <= 1'b0;
        end else begin
            sync_q    <= {sync_q[SYNC_STAGES-2:0], pclk_in};
            last_q    <= sync_q[SYNC_STAGES-1];
            pclk_edge <= sync_q[SYNC_STAGES-1] ^ last_q;
        end
    end

endmodule

// File: rtl/tft_pclk_monitor.sv
// Measures pixel-clock half-periods in clk cycles, locks onto a stable value
// and reports the equivalent clock_divide setting plus loss-of-clock.
module tft_pclk_monitor
    import tft_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4,
    parameter int TOLERANCE   = 1,
    parameter int TIMEOUT     = 65536
) (
    input  logic                clk,
    input  logic                rst,
    tft_pclk_monitor_if.master  mon
);

    localparam int                    MATCH_W    = $clog2(LOCK_COUNT + 1);
    localparam logic [TFT_HALF_W-1:0] CNT_MAX    = TFT_HALF_W'(TIMEOUT);
    localparam logic [MATCH_W-1:0]    MATCH_LOCK = MATCH_W'(LOCK_COUNT);
    localparam logic [TFT_HALF_W:0]   TOL        = (TFT_HALF_W + 1)'(TOLERANCE);

    logic                  pclk_edge;
    logic [TFT_HALF_W-1:0] cnt;
    logic [TFT_HALF_W-1:0] meas;
    logic [TFT_HALF_W-1:0] ref_val;
    logic [MATCH_W-1:0]    match_q;
    logic [MATCH_W-1:0]    match_nxt;
    logic [1:0]            state;
    logic                  in_tol;
    logic                  tmo_hit;

    tft_pclk_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk       (clk),
        .rst       (rst),
        .pclk_in   (mon.pclk_in),
        .pclk_edge (pclk_edge)
    );

    assign meas      = cnt + 1'b1;
    assign match_nxt = match_q + 1'b1;
    assign in_tol    = (tft_abs_diff(meas, ref_val) <= TOL);
    // An edge in the saturation cycle clears cnt, so it wins over the timeout.
    assign tmo_hit   = (state != ST_IDLE) && (cnt == CNT_MAX) && !pclk_edge;

    always_ff @(posedge clk) begin
        if (rst || pclk_edge)
            cnt <= '0;
        else if (cnt != CNT_MAX)
            cnt <= cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            ref_val          <= '0;
            match_q          <= '0;
            mon.clock_divide <= '0;
            mon.lock         <= 1'b0;
            mon.meas_stb     <= 1'b0;
            mon.meas_value   <= '0;
            mon.timeout      <= 1'b0;
        end else begin
            mon.meas_stb <= 1'b0;
            mon.timeout  <= 1'b0;
            if (pclk_edge) begin
                if (state != ST_IDLE) begin
                    mon.meas_stb   <= 1'b1;
                    mon.meas_value <= meas;
                end
                case (state)
                    // First edge has no preceding reference point; drop it.
                    ST_IDLE: state <= ST_ACQ_FIRST;
                    ST_ACQ_FIRST: begin
                        ref_val <= meas;
                        match_q <= MATCH_W'(1);
                        state   <= ST_ACQUIRE;
                    end
                    ST_ACQUIRE: begin
                        if (in_tol) begin
                            match_q <= match_nxt;
                            if (match_nxt == MATCH_LOCK) begin
                                state            <= ST_LOCKED;
                                mon.lock         <= 1'b1;
                                mon.clock_divide <= TFT_DIV_W'(ref_val - 1'b1);
                            end
                        end else begin
                            ref_val <= meas;
                            match_q <= MATCH_W'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (!in_tol) begin
                            mon.lock <= 1'b0;
                            ref_val  <= meas;
                            match_q  <= MATCH_W'(1);
                            state    <= ST_ACQUIRE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end else if (tmo_hit) begin
                mon.timeout <= 1'b1;
                mon.lock    <= 1'b0;
                state       <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_tft_pclk_monitor.sv
// Directed bench for tft_pclk_monitor: lock at several divides, tolerance,
// relock, timeout and mid-acquisition reset.
module tb_tft_pclk_monitor;
    import tft_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;

    tft_pclk_monitor_if mif();

    tft_pclk_monitor #(
        .SYNC_STAGES (2),
        .LOCK_COUNT  (4),
        .TOLERANCE   (1),
        .TIMEOUT     (65536)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .mon (mif.master)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_stb = 0;
    int stb_cnt = 0;
    int to_cnt = 0;
    int to_delta = 0;

    always @(negedge clk) begin
        cyc++;
        if (mif.meas_stb) begin
            stb_cnt++;
            last_stb = cyc;
        end
        if (mif.timeout) begin
            to_cnt++;
            to_delta = cyc - last_stb;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Toggle pclk_in, then hold it for n clk cycles (the next half-period).
    task automatic tog(input int n);
        mif.pclk_in = ~mif.pclk_in;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        mif.pclk_in = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
        stb_cnt = 0;
    endtask

    initial begin
        mif.pclk_in = 1'b0;
        do_reset();
        chk("rst_lock", 32'(mif.lock), 0);
        chk("rst_div", 32'(mif.clock_divide), 0);
        chk("rst_stb", 32'(mif.meas_stb), 0);
        chk("rst_val", 32'(mif.meas_value), 0);
        chk("rst_tmo", 32'(mif.timeout), 0);
        chk("rst_state", 32'(u_dut.state), 32'(ST_IDLE));

        // Divide 3: half-period 4, lock on edge 5.
        repeat (4) tog(4);
        chk("d3_nolock4", 32'(mif.lock), 0);
        chk("d3_stbcnt", 32'(stb_cnt), 3);
        chk("d3_val", 32'(mif.meas_value), 4);
        tog(11);
        chk("d3_lock5", 32'(mif.lock), 1);
        chk("d3_div", 32'(mif.clock_divide), 3);

        // Switch to half-period 11: drop on first, relock after 4 matches.
        tog(11);
        chk("d10_drop", 32'(mif.lock), 0);
        chk("d10_val", 32'(mif.meas_value), 11);
        chk("d10_div_kept", 32'(mif.clock_divide), 3);
        tog(11);
        tog(11);
        chk("d10_nolock", 32'(mif.lock), 0);
        tog(10);
        chk("d10_lock", 32'(mif.lock), 1);
        chk("d10_div", 32'(mif.clock_divide), 10);

        // Divide 0: toggle every clk.
        do_reset();
        repeat (8) tog(1);
        repeat (6) @(negedge clk);
        #1;
        chk("d0_lock", 32'(mif.lock), 1);
        chk("d0_div", 32'(mif.clock_divide), 0);
        chk("d0_val", 32'(mif.meas_value), 1);
        chk("d0_stbcnt", 32'(stb_cnt), 7);

        // Divide 9 with jitter inside tolerance, then an out-of-range 13.
        do_reset();
        repeat (5) tog(10);
        chk("d9_lock", 32'(mif.lock), 1);
        chk("d9_div", 32'(mif.clock_divide), 9);
        tog(11);
        tog(9);
        tog(13);
        chk("d9_jit_lock", 32'(mif.lock), 1);
        chk("d9_jit_div", 32'(mif.clock_divide), 9);
        chk("d9_jit_val", 32'(mif.meas_value), 9);
        tog(6);
        chk("d9_drop", 32'(mif.lock), 0);
        chk("d9_drop_val", 32'(mif.meas_value), 13);

        // Relock at divide 5, then stop the clock.
        repeat (4) tog(6);
        chk("d5_lock", 32'(mif.lock), 1);
        chk("d5_div", 32'(mif.clock_divide), 5);
        to_cnt = 0;
        for (int i = 0; i < 70000 && to_cnt == 0; i++) @(negedge clk);
        #1;
        chk("tmo_seen", 32'(to_cnt), 1);
        chk("tmo_delta", 32'(to_delta), 65537);
        repeat (20) @(negedge clk);
        #1;
        chk("tmo_once", 32'(to_cnt), 1);
        chk("tmo_lock", 32'(mif.lock), 0);
        chk("tmo_state", 32'(u_dut.state), 32'(ST_IDLE));
        chk("tmo_div_kept", 32'(mif.clock_divide), 5);

        // Resume toggling: fresh discard edge then relock at divide 3.
        repeat (4) tog(4);
        chk("re_nolock", 32'(mif.lock), 0);
        tog(4);
        chk("re_lock", 32'(mif.lock), 1);
        chk("re_div", 32'(mif.clock_divide), 3);

        // Move to half-period 8 and reset with three matches accumulated.
        tog(8);
        tog(8);
        tog(8);
        tog(8);
        chk("mid_state", 32'(u_dut.state), 32'(ST_ACQUIRE));
        chk("mid_match", 32'(u_dut.match_q), 3);
        chk("mid_val", 32'(mif.meas_value), 8);
        rst = 1'b1;
        mif.pclk_in = 1'b0;
        @(negedge clk);
        #1;
        chk("mrst_div", 32'(mif.clock_divide), 0);
        chk("mrst_val", 32'(mif.meas_value), 0);
        chk("mrst_lock", 32'(mif.lock), 0);
        chk("mrst_state", 32'(u_dut.state), 32'(ST_IDLE));
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        repeat (4) tog(4);
        chk("mrst_nolock", 32'(mif.lock), 0);
        tog(4);
        chk("mrst_lock5", 32'(mif.lock), 1);
        chk("mrst_div3", 32'(mif.clock_divide), 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tft_pclk_monitor.md
# tft_pclk_monitor

Measures an externally supplied TFT pixel clock, sampled in the system `clk` domain, and recovers the equivalent 16-bit `clock_divide` setting (the pixel clock toggles every `clock_divide+1` `clk` cycles). It qualifies the input with a lock state machine and reports loss of clock. It sits on the TFT slave's input side, feeding status registers and letting the display path track a panel-sourced clock.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth for `pclk_in` (≥2).
- `LOCK_COUNT`, 4: consecutive in-tolerance half-period measurements required to lock (≥2).
- `TOLERANCE`, 1: allowed |measurement − reference| in `clk` cycles.
- `TIMEOUT`, 65536: maximum valid half-period in `clk` cycles; must be ≤65536.
- `clk` in 1: system clock. Reset `rst`, synchronous, active-high; clock `clk`.
- `rst` in 1: synchronous reset, active-high.
- `pclk_in` in 1: pixel clock under test, asynchronous to `clk`.
- `clock_divide` out 16: recovered divide value; valid while `lock`=1.
- `lock` out 1: recovered value stable.
- `meas_stb` out 1: one-cycle pulse per accepted half-period measurement.
- `meas_value` out 17: last half-period in `clk` cycles; updated with `meas_stb`.
- `timeout` out 1: one-cycle pulse when no edge is seen for more than `TIMEOUT` cycles.

## Operation
- `pclk_in` passes through `SYNC_STAGES` flops, then an edge-detect flop. Any transition, rising or falling, produces `edge`=1 for one cycle.
- Half-period counter `cnt` is 17 bits:
  - On `edge`: `cnt`←0; candidate measurement m = `cnt`+1.
  - Otherwise `cnt`←`cnt`+1, saturating at `TIMEOUT`.
  - Edges spaced N cycles apart give m = N.
- States:
  - IDLE: waits for the first `edge`. That edge is discarded (no `meas_stb`) and moves to ACQ_FIRST.
  - ACQ_FIRST: on `edge`, `ref`←m, `match`←1, pulse `meas_stb`, go to ACQUIRE.
  - ACQUIRE: on `edge`, pulse `meas_stb`.
    - If |m−`ref`| ≤ `TOLERANCE`: `match`←`match`+1.
    - Otherwise: `ref`←m, `match`←1.
    - When `match` reaches `LOCK_COUNT`: go to LOCKED, `clock_divide`←`ref`−1, `lock`←1.
  - LOCKED: on `edge`, pulse `meas_stb`.
    - If in tolerance: stay. `clock_divide` and `ref` are unchanged.
    - If out of tolerance: `lock`←0, `ref`←m, `match`←1, go to ACQUIRE.
  - Any state except IDLE: if `cnt`==`TIMEOUT` and no `edge` that cycle → pulse `timeout`, `lock`←0, go to IDLE.
- The same-cycle edge and timeout condition resolves to the edge, since `cnt` clears.
- `clock_divide` keeps its last value after lock loss. Qualify it with `lock`.
- Arithmetic:
  - m ranges 1..`TIMEOUT`, so `ref`−1 fits in 16 bits.
  - The |m−`ref`| comparison uses 18-bit signed or ordered subtraction, with no wrap.

## Timing
- Reset values: `clock_divide`=0, `lock`=0, `meas_stb`=0, `meas_value`=0, `timeout`=0, state IDLE, `cnt`=0, all synchronizer and edge flops 0.
- If `pclk_in` is high at reset release, one spurious edge is detected. It is consumed as the IDLE discard edge.
- `edge` asserts `SYNC_STAGES`+1 cycles after a `pclk_in` transition.
- `meas_stb`, `meas_value`, and state updates register one cycle after `edge`.
- `lock` rises one cycle after the `LOCK_COUNT`-th matching measurement, at edge number `LOCK_COUNT`+1 after reset for clean input.
- `lock` falls one cycle after the offending `edge`, or together with `timeout`.
- Reset mid-operation returns everything to reset values on the next clock. There are no partial measurements.
- Minimum half-period is 1 cycle (`pclk_in` toggling every `clk`). Input faster than that aliases and is out of scope.

## Structure
- Shared package `tft_pkg`:
  - state encoding (IDLE, ACQ_FIRST, ACQUIRE, LOCKED);
  - `TFT_DIV_W`=16;
  - `TFT_HALF_W`=17.
- Sub-module `tft_pclk_sync`: `SYNC_STAGES` synchronizer plus edge detector, output `edge`.
- The counter, comparison, and FSM stay in `tft_pclk_monitor`.

## Test plan
- `pclk_in` toggling every 4 cycles (divide 3) → `meas_value`=4 on each strobe; `lock`=1 after the 5th edge; `clock_divide`=3.
- Toggling every cycle (divide 0) → `lock`=1, `clock_divide`=0.
- Locked at divide 3, switch to toggling every 11 cycles → `lock` falls on the first 11-cycle edge, then relocks with `clock_divide`=10 after 4 matching measurements.
- Locked at divide 9, half-periods alternating 10/11/9 → `lock` stays 1 and `clock_divide` stays 9. A half-period of 13 drops `lock`.
- Locked, then `pclk_in` held constant → `timeout` pulses exactly once at 65537 cycles after the last edge, `lock`=0, state IDLE, then relock on resumed toggling.
- `rst` asserted in ACQUIRE with `match`=3 → all outputs 0 next cycle, and lock requires a full fresh `LOCK_COUNT`+1 edges.
